vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

Generates 640x480 at 60 Hz VGA timing for the single-player tic-tac-toe display. It derives a one-cycle pixel tick from the 100 MHz system clock and runs horizontal and vertical counters. It drives `x`, `y` and `en` into the downstream graphics/colour stage. `hsync` and `vsync` are delayed so they line up with that stage's registered colour output, which lags by BRAM latency plus one output register.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: hsync pulse width, in pixels
- `H_BP`, 48: horizontal back porch, in pixels
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vsync pulse width, in lines
- `V_BP`, 33: vertical back porch, in lines
- `CLK_DIV`, 4: clk cycles per pixel (≥2)
- `SYNC_DELAY`, 2: clk cycles of delay on hsync/vsync (≥0)
- `clk` in 1: 100 MHz system clock, the only clock
- `reset` in 1: asynchronous, active-high
- `x` out 10: horizontal pixel count, 0..H_TOTAL-1
- `y` out 10: vertical line count, 0..V_TOTAL-1
- `en` out 1: high while x<H_ACTIVE and y<V_ACTIVE
- `p_tick` out 1: one-clk strobe, once per pixel period
- `hsync` out 1: active-low, delayed by SYNC_DELAY
- `vsync` out 1: active-low, delayed by SYNC_DELAY
- `frame_start` out 1: one-clk strobe on the last pixel of the frame

## Operation
- Derived totals:
  - H_TOTAL = 800 and V_TOTAL = 525 with the defaults.
  - Both fit in 10 bits.
  - Parameters must keep the totals ≤1024.
- Divider:
  - `div` counts 0..CLK_DIV-1 and wraps.
  - `p_tick` = (div==CLK_DIV-1).
- Horizontal counter: advances only on `p_tick`. From H_TOTAL-1 it wraps to 0.
- Vertical counter:
  - Advances on `p_tick` together with the horizontal wrap.
  - From V_TOTAL-1 it wraps to 0.
  - At (H_TOTAL-1, V_TOTAL-1) both counters wrap in the same clk edge.
- `x` and `y` are the counter registers themselves, so they are held stable for CLK_DIV clks.
- `en` is combinational from the registered counters, so it is glitch-free.
- Raw sync signals:
  - hsync_raw = 0 iff H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vsync_raw = 0 iff V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
- Sync delay:
  - Each raw sync passes through SYNC_DELAY clk-stage registers, which reset to 1.
  - With SYNC_DELAY=0 the raw sync is output directly.
- `frame_start` = p_tick && x==H_TOTAL-1 && y==V_TOTAL-1. Game logic uses it to update cell/selection state between frames.

## Timing
- Reset values:
  - div=0, x=0, y=0, p_tick=0, frame_start=0.
  - hsync=1 and vsync=1, including every delay stage.
  - en=1, since (0,0) is an active pixel.
- After reset is released:
  - First `p_tick` is in the CLK_DIV-th clk, i.e. div==3 on the 4th rising edge.
  - x becomes 1 on the following edge.
- Periods with the default clock and divider:
  - Line: 800×4 = 3200 clk.
  - Frame: 525×3200 = 1,680,000 clk.
  - hsync low for 96×4 = 384 clk per line.
  - vsync low for 2×3200 = 6400 clk per frame.
- Latency:
  - hsync/vsync edges appear SYNC_DELAY clks after the x/y change that causes them.
  - This matches colour registered SYNC_DELAY clks after x/y.
- `en` has zero latency relative to x/y; the downstream stage applies its own registration.
- Reset mid-frame: all registers return to their reset values immediately and asynchronously. No partial line or frame is completed, and the next frame starts at (0,0).
- No back-pressure: the counters free-run.

## Structure
- Shared package `vga_timing_pkg`:
  - Default H/V active, porch and sync constants.
  - H_TOTAL and V_TOTAL.
  - Sync start/end constants.
  - Shared with the graphics stage for cell-geometry derivation.
- One sub-module `vga_delay_line`: a parameterised depth×width shift register, reset to 1, instantiated once for {hsync, vsync}.
- Top level holds the divider, both counters, the decode logic and `frame_start`.

## Test plan
- Reset, then release:
  - Outputs read x=0, y=0, en=1, hsync=1, vsync=1, p_tick=0.
  - First p_tick is on clk 4 and x=1 on clk 5.
  - Thereafter p_tick pulses exactly every 4 clks.
- Run one line:
  - x sequence is 0..799, then 0, and y increments once.
  - en falls when x becomes 640.
  - hsync is low for exactly 384 clks, starting 2 clks after x becomes 656.
- Run a full frame:
  - 1,680,000 clks between successive frame_start pulses.
  - vsync is low for 6400 clks, starting 2 clks after y becomes 490.
  - en stays 0 for y in 480..524.
- Frame wrap: at (799,524) with p_tick, frame_start=1 for exactly one clk, and the next edge gives x=0, y=0 simultaneously.
- Assert reset at x=700, y=300 mid-pulse: x, y and div become 0 and hsync becomes 1 with no clock edge. Normal timing resumes after release.
- SYNC_DELAY=0 build: hsync falls in the same clk that x becomes 656.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants for the sync generator and the graphics stage.
// Defaults describe 640x480 at 60 Hz, with a 100 MHz clock divided by 4.
package vga_timing_pkg;

  // Width of the x/y counters. Both totals must stay at or below 1024.
  localparam int CNT_W = 10;

  // Horizontal timing, in pixels.
  localparam int DFLT_H_ACTIVE = 640;
  localparam int DFLT_H_FP     = 16;
  localparam int DFLT_H_SYNC   = 96;
  localparam int DFLT_H_BP     = 48;

  // Vertical timing, in lines.
  localparam int DFLT_V_ACTIVE = 480;
  localparam int DFLT_V_FP     = 10;
  localparam int DFLT_V_SYNC   = 2;
  localparam int DFLT_V_BP     = 33;

  // Clock-to-pixel divider, and the sync delay that matches the colour pipeline.
  localparam int DFLT_CLK_DIV    = 4;
  localparam int DFLT_SYNC_DELAY = 2;

  // Derived totals and sync windows. Each window is half-open: [start, end).
  localparam int H_TOTAL      = DFLT_H_ACTIVE + DFLT_H_FP + DFLT_H_SYNC + DFLT_H_BP;
  localparam int V_TOTAL      = DFLT_V_ACTIVE + DFLT_V_FP + DFLT_V_SYNC + DFLT_V_BP;
  localparam int H_SYNC_START = DFLT_H_ACTIVE + DFLT_H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + DFLT_H_SYNC;
  localparam int V_SYNC_START = DFLT_V_ACTIVE + DFLT_V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + DFLT_V_SYNC;

  // The pair of sync signals, carried together through the delay line.
  typedef struct packed {
    logic hsync;
    logic vsync;
  } sync_t;

  // Returns 1 when lo <= v < hi.
  function automatic logic in_window(input logic [CNT_W-1:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// A shift register DEPTH stages deep and WIDTH bits wide. Every stage resets to all ones,
// so active-low syncs stay idle. When DEPTH is 0, the input passes straight through.
module vga_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign dout = din;
    end else begin : g_pipe
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [WIDTH-1:0] stage_in;
        logic [WIDTH-1:0] q_reg;

        if (gi == 0) begin : g_first
          assign stage_in = din;
        end else begin : g_rest
          assign stage_in = g_stage[gi-1].q_reg;
        end

        // One pipeline stage. It resets to idle (all ones).
        always_ff @(posedge clk or posedge reset) begin
          if (reset) q_reg <= '1;
          else       q_reg <= stage_in;
        end
      end
      assign dout = g_stage[DEPTH-1].q_reg;
    end
  endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator. A clock divider produces the pixel tick, and the tick drives the
// horizontal and vertical counters. Decode logic produces en, the raw syncs and frame_start.
// The syncs are delayed so they line up with the registered colour output downstream.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = DFLT_H_ACTIVE,
  parameter int H_FP       = DFLT_H_FP,
  parameter int H_SYNC     = DFLT_H_SYNC,
  parameter int H_BP       = DFLT_H_BP,
  parameter int V_ACTIVE   = DFLT_V_ACTIVE,
  parameter int V_FP       = DFLT_V_FP,
  parameter int V_SYNC     = DFLT_V_SYNC,
  parameter int V_BP       = DFLT_V_BP,
  parameter int CLK_DIV    = DFLT_CLK_DIV,
  parameter int SYNC_DELAY = DFLT_SYNC_DELAY
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             en,
  output logic             p_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_start
);

  localparam int H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_LO  = H_ACTIVE + H_FP;
  localparam int HS_HI  = HS_LO + H_SYNC;
  localparam int VS_LO  = V_ACTIVE + V_FP;
  localparam int VS_HI  = VS_LO + V_SYNC;
  localparam int DIV_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);

  logic [DIV_W-1:0] div_reg, div_next;
  logic [CNT_W-1:0] h_reg, h_next;
  logic [CNT_W-1:0] v_reg, v_next;
  logic             tick;
  logic             h_wrap;
  sync_t            sync_raw;
  sync_t            sync_dly;

  // Next-state logic for the divider and both counters. The counters move only on the tick.
  always_comb begin
    tick     = (div_reg == DIV_LAST);
    h_wrap   = (h_reg == H_LAST);
    div_next = div_reg + DIV_W'(1);
    h_next   = h_reg;
    v_next   = v_reg;
    if (tick) begin
      div_next = '0;
      h_next   = h_wrap ? '0 : h_reg + CNT_W'(1);
      if (h_wrap) begin
        v_next = (v_reg == V_LAST) ? '0 : v_reg + CNT_W'(1);
      end
    end
  end

  // Registers for the divider and the counters. Reset clears them at once, so the next
  // frame starts at (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_reg <= '0;
      h_reg   <= '0;
      v_reg   <= '0;
    end else begin
      div_reg <= div_next;
      h_reg   <= h_next;
      v_reg   <= v_next;
    end
  end

  // Decode taken straight from the registered counters. It does not glitch and has no
  // latency relative to x and y.
  always_comb begin
    sync_raw.hsync = ~in_window(h_reg, HS_LO, HS_HI);
    sync_raw.vsync = ~in_window(v_reg, VS_LO, VS_HI);
  end

  assign x           = h_reg;
  assign y           = v_reg;
  assign p_tick      = tick;
  assign en          = (h_reg < H_VIS) && (v_reg < V_VIS);
  assign frame_start = tick && h_wrap && (v_reg == V_LAST);

  // Delays the syncs to match the downstream colour pipeline (BRAM read plus output register).
  vga_delay_line #(
    .DEPTH (SYNC_DELAY),
    .WIDTH ($bits(sync_t))
  ) u_sync_dly (
    .clk   (clk),
    .reset (reset),
    .din   (sync_raw),
    .dout  (sync_dly)
  );

  assign hsync = sync_dly.hsync;
  assign vsync = sync_dly.vsync;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen. It runs three builds: the default timing, a reduced timing with
// SYNC_DELAY=2, and a reduced timing with SYNC_DELAY=0. An arithmetic model derives every
// output from the count of clock edges since reset was released.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [9:0] x_d, y_d, x_s, y_s, x_z, y_z;
  logic en_d, pt_d, hs_d, vs_d, fs_d;
  logic en_s, pt_s, hs_s, vs_s, fs_s;
  logic en_z, pt_z, hs_z, vs_z, fs_z;

  vga_sync_gen dut_def (
    .clk(clk), .reset(reset), .x(x_d), .y(y_d), .en(en_d), .p_tick(pt_d),
    .hsync(hs_d), .vsync(vs_d), .frame_start(fs_d)
  );

  // Reduced timing: H_TOTAL = 25, V_TOTAL = 12, 1200 clocks per frame.
  vga_sync_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .CLK_DIV(4), .SYNC_DELAY(2)
  ) dut_sm (
    .clk(clk), .reset(reset), .x(x_s), .y(y_s), .en(en_s), .p_tick(pt_s),
    .hsync(hs_s), .vsync(vs_s), .frame_start(fs_s)
  );

  vga_sync_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .CLK_DIV(4), .SYNC_DELAY(0)
  ) dut_z (
    .clk(clk), .reset(reset), .x(x_z), .y(y_z), .en(en_z), .p_tick(pt_z),
    .hsync(hs_z), .vsync(vs_z), .frame_start(fs_z)
  );

  // Count of rising edges since reset was last released.
  int n;
  always @(posedge clk or posedge reset) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  int tests = 0;
  int fails = 0;
  bit check_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, n, act, exp);
      if (fails > 40) begin
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
    end
  endtask

  // Expected outputs after k edges, packed as {x, y, en, p_tick, hsync, vsync, frame_start}.
  function automatic logic [24:0] model(input int k, input int d,
                                        input int ha, input int hfp, input int hsw, input int hbp,
                                        input int va, input int vfp, input int vsw, input int vbp,
                                        input int sd);
    int ht, vt, t, px, py, mt, mx, my;
    logic pt, e, fs, hsv, vsv;
    ht  = ha + hfp + hsw + hbp;
    vt  = va + vfp + vsw + vbp;
    t   = k / d;
    px  = t % ht;
    py  = (t / ht) % vt;
    pt  = ((k % d) == d - 1);
    e   = (px < ha) && (py < va);
    fs  = pt && (px == ht - 1) && (py == vt - 1);
    hsv = 1'b1;
    vsv = 1'b1;
    if (k >= sd) begin
      mt  = (k - sd) / d;
      mx  = mt % ht;
      my  = (mt / ht) % vt;
      hsv = !((mx >= ha + hfp) && (mx < ha + hfp + hsw));
      vsv = !((my >= va + vfp) && (my < va + vfp + vsw));
    end
    return {10'(px), 10'(py), e, pt, hsv, vsv, fs};
  endfunction

  // Checks every instance against the model on every cycle while reset is low.
  always @(negedge clk) begin
    if (check_on && !reset) begin
      check("cyc_def", 32'({x_d, y_d, en_d, pt_d, hs_d, vs_d, fs_d}),
            32'(model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33, 2)));
      check("cyc_sm", 32'({x_s, y_s, en_s, pt_s, hs_s, vs_s, fs_s}),
            32'(model(n, 4, 16, 2, 4, 3, 6, 2, 2, 2, 2)));
      check("cyc_z", 32'({x_z, y_z, en_z, pt_z, hs_z, vs_z, fs_z}),
            32'(model(n, 4, 16, 2, 4, 3, 6, 2, 2, 2, 0)));
    end
  end

  int hs_first, hs_low, vs_first, vs_low, fs_last, fs_cnt, hsz_low;
  bit found;

  initial begin
    hs_first = -1; hs_low = 0; vs_first = -1; vs_low = 0;
    fs_last = -1; fs_cnt = 0; hsz_low = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    // Values while reset is held, before any clock edge after release.
    check("rst_x", 32'(x_d), 32'd0);
    check("rst_y", 32'(y_d), 32'd0);
    check("rst_en", 32'(en_d), 32'd1);
    check("rst_pt", 32'(pt_d), 32'd0);
    check("rst_hs", 32'(hs_d), 32'd1);
    check("rst_vs", 32'(vs_d), 32'd1);
    check("rst_fs", 32'(fs_d), 32'd0);
    reset = 1'b0;
    check_on = 1'b1;
    $display("[TB] reset released");

    for (int i = 1; i <= 3300; i++) begin
      @(negedge clk);
      if (i == 2)    check("pt_early", 32'(pt_d), 32'd0);
      if (i == 3)    check("pt_first", 32'(pt_d), 32'd1);
      if (i == 3)    check("x_before_tick", 32'(x_d), 32'd0);
      if (i == 4)    check("x_after_tick", 32'(x_d), 32'd1);
      if (i == 7)    check("pt_second", 32'(pt_d), 32'd1);
      if (i == 2559) check("en_x639", 32'(en_d), 32'd1);
      if (i == 2560) check("x_640", 32'(x_d), 32'd640);
      if (i == 2560) check("en_x640", 32'(en_d), 32'd0);
      if (i == 3199) check("line_end", 32'({x_d, y_d}), 32'({10'd799, 10'd0}));
      if (i == 3200) check("line_wrap", 32'({x_d, y_d}), 32'({10'd0, 10'd1}));
      if (i == 71)   check("z_hs_before", 32'(hs_z), 32'd1);
      if (i == 72)   check("z_hs_fall", 32'(hs_z), 32'd0);
      if (i < 100 && !hs_z) hsz_low++;
      if (!hs_d) begin
        if (hs_first < 0) hs_first = i;
        hs_low++;
      end
      if (i < 1202 && !vs_s) begin
        if (vs_first < 0) vs_first = i;
        vs_low++;
      end
      if (fs_s) begin
        if (fs_last < 0) check("fs_first", 32'(i), 32'd1199);
        else             check("fs_period", 32'(i - fs_last), 32'd1200);
        fs_last = i;
        fs_cnt++;
      end
    end
    check("hs_start", 32'(hs_first), 32'd2626);
    check("hs_width", 32'(hs_low), 32'd384);
    check("vs_start", 32'(vs_first), 32'd802);
    check("vs_width", 32'(vs_low), 32'd200);
    check("fs_count", 32'(fs_cnt), 32'd2);
    check("z_hs_width", 32'(hsz_low), 32'd16);
    $display("[TB] line/frame run done, %0d frame_start pulses", fs_cnt);

    // Reset in the middle of an hsync pulse of the reduced build.
    found = 1'b0;
    for (int i = 0; i < 1300 && !found; i++) begin
      @(negedge clk);
      if (x_s == 10'd20 && y_s == 10'd5) found = 1'b1;
    end
    check("mid_wait", 32'(found), 32'd1);
    repeat (2) @(negedge clk);
    check("mid_hs_low", 32'(hs_s), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("async_x", 32'(x_s), 32'd0);
    check("async_y", 32'(y_s), 32'd0);
    check("async_hs", 32'(hs_s), 32'd1);
    check("async_pt", 32'(pt_s), 32'd0);
    check("async_def_x", 32'(x_d), 32'd0);
    $display("[TB] asynchronous reset applied mid-line");
    @(negedge clk);
    reset = 1'b0;

    fs_last = -1;
    for (int i = 1; i <= 1300; i++) begin
      @(negedge clk);
      if (i == 4) check("resume_x", 32'(x_s), 32'd1);
      if (fs_s) begin
        if (fs_last < 0) check("resume_fs", 32'(i), 32'd1199);
        fs_last = i;
      end
    end
    check("resume_fs_seen", 32'(fs_last), 32'd1199);
    $display("[TB] resumed after reset");

    check_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
